// File: rtl/pdp_pkg.sv
// Shared encodings for the pdp sequencer and the 4-bit accumulator core it drives.
package pdp_pkg;

   typedef enum logic [1:0] {
      CMD_RESET     = 2'd0,
      CMD_LOAD_CODE = 2'd1,
      CMD_LOAD_DATA = 2'd2,
      CMD_RUN       = 2'd3
   } pdp_cmd_e;

   typedef enum logic [1:0] {
      INSTR_LOAD  = 2'd0,
      INSTR_STORE = 2'd1,
      INSTR_ADD   = 2'd2,
      INSTR_BZ    = 2'd3
   } pdp_instr_e;

   // Sequencer states; kept as plain constants so older tools can share the encoding.
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_RST0  = 3'd1;
   localparam logic [2:0] ST_LCODE = 3'd2;
   localparam logic [2:0] ST_RST1  = 3'd3;
   localparam logic [2:0] ST_LDATA = 3'd4;
   localparam logic [2:0] ST_RST2  = 3'd5;
   localparam logic [2:0] ST_RUN   = 3'd6;
   localparam logic [2:0] ST_DONE  = 3'd7;

   localparam int IO_CLK_BIT = 0;
   localparam int IO_CMD_LSB = 1;
   localparam int IO_ARG_LSB = 4;

   function automatic logic [7:0] pack_io(input pdp_cmd_e cmd, input logic [3:0] arg,
                                          input logic cpu_clk);
      logic [7:0] io;
      io = '0;
      io[IO_CLK_BIT]      = cpu_clk;
      io[IO_CMD_LSB +: 2] = cmd;
      io[IO_ARG_LSB +: 4] = arg;
      return io;
   endfunction

endpackage

// File: rtl/pdp_sequencer_if.sv
// Command/status bus between the sequencer (master) and the accumulator core (slave).
interface pdp_sequencer_if #(
   parameter int CORE_IO_W = 8
);
   logic [CORE_IO_W-1:0] cpu_io_in;
   logic [CORE_IO_W-1:0] cpu_io_out;

   modport master (output cpu_io_in, input cpu_io_out);
   modport slave (input cpu_io_in, output cpu_io_out);
endinterface

// File: rtl/pdp_cmd_phase.sv
// Two-cycle SETUP/PULSE generator: holds cmd/arg with cpu_clk low, then high, then reports op_done.
module pdp_cmd_phase
   import pdp_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clear,
   input  logic       op_valid,
   input  pdp_cmd_e   cmd,
   input  logic [3:0] arg,
   output logic       op_done,
   output logic [7:0] io
);

   logic pulse;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pulse <= 1'b0;
      end else if (clear || !op_valid) begin
         pulse <= 1'b0;
      end else begin
         pulse <= ~pulse;
      end
   end

   assign op_done = op_valid & pulse;
   assign io      = op_valid ? pack_io(cmd, arg, pulse) : 8'h00;

endmodule

// File: rtl/pdp_sequencer.sv
// Host-side load-and-run controller for the 4-bit accumulator core.
// Loads the full code/data image, resets to the entry pc, then steps the core until halt or limit.
module pdp_sequencer
   import pdp_pkg::*;
#(
   parameter int STEP_W    = 8,
   parameter int CORE_IO_W = 8
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [15:0]       prog_code,
   input  logic [31:0]       prog_data,
   input  logic [2:0]        start_pc,
   input  logic [STEP_W-1:0] run_steps,
   pdp_sequencer_if.master   core,
   output logic              busy,
   output logic              done,
   output logic              halted,
   output logic [STEP_W-1:0] steps_taken
);

   logic [2:0]           state;
   logic [2:0]           slot;
   logic                 run_check;
   logic [15:0]          code_q;
   logic [31:0]          data_q;
   logic [2:0]           pc_q;
   logic [STEP_W-1:0]    limit_q;
   logic [CORE_IO_W-1:0] snapshot;
   logic [STEP_W-1:0]    steps_next;
   logic                 op_valid;
   logic                 op_done;
   pdp_cmd_e             cmd;
   logic [3:0]           arg;
   logic [7:0]           phase_io;

   always_comb begin
      op_valid = 1'b0;
      cmd      = CMD_RESET;
      arg      = 4'h0;
      case (state)
         ST_RST0, ST_RST1: op_valid = 1'b1;
         ST_LCODE: begin
            op_valid = 1'b1;
            cmd      = CMD_LOAD_CODE;
            arg      = {2'b00, code_q[{slot, 1'b0} +: 2]};
         end
         ST_LDATA: begin
            op_valid = 1'b1;
            cmd      = CMD_LOAD_DATA;
            arg      = data_q[{slot, 2'b00} +: 4];
         end
         ST_RST2: begin
            op_valid = 1'b1;
            arg      = {1'b0, pc_q};
         end
         ST_RUN: begin
            op_valid = !run_check;
            cmd      = CMD_RUN;
         end
         default: ;
      endcase
   end

   assign steps_next = (&steps_taken) ? steps_taken : steps_taken + 1'b1;

   pdp_cmd_phase u_phase (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (abort),
      .op_valid (op_valid),
      .cmd      (cmd),
      .arg      (arg),
      .op_done  (op_done),
      .io       (phase_io)
   );

   assign core.cpu_io_in = phase_io;

   // A Run step is SETUP (snapshot), PULSE, then a CHECK cycle; an unchanged status means a self-branch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         slot        <= 3'd0;
         run_check   <= 1'b0;
         code_q      <= '0;
         data_q      <= '0;
         pc_q        <= 3'd0;
         limit_q     <= '0;
         snapshot    <= '0;
         halted      <= 1'b0;
         steps_taken <= '0;
      end else if (abort && state != ST_IDLE) begin
         state     <= ST_IDLE;
         slot      <= 3'd0;
         run_check <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start && !abort) begin
                  code_q      <= prog_code;
                  data_q      <= prog_data;
                  pc_q        <= start_pc;
                  limit_q     <= run_steps;
                  halted      <= 1'b0;
                  steps_taken <= '0;
                  slot        <= 3'd0;
                  run_check   <= 1'b0;
                  state       <= ST_RST0;
               end
            end
            ST_RST0: if (op_done) state <= ST_LCODE;
            ST_LCODE: begin
               if (op_done) begin
                  slot <= slot + 3'd1;
                  if (slot == 3'd7) state <= ST_RST1;
               end
            end
            ST_RST1: if (op_done) state <= ST_LDATA;
            ST_LDATA: begin
               if (op_done) begin
                  slot <= slot + 3'd1;
                  if (slot == 3'd7) state <= ST_RST2;
               end
            end
            ST_RST2: if (op_done) state <= (limit_q == '0) ? ST_DONE : ST_RUN;
            ST_RUN: begin
               if (run_check) begin
                  steps_taken <= steps_next;
                  run_check   <= 1'b0;
                  if (core.cpu_io_out == snapshot) begin
                     halted <= 1'b1;
                     state  <= ST_DONE;
                  end else if (steps_next >= limit_q) begin
                     state <= ST_DONE;
                  end
               end else if (!op_done) begin
                  snapshot <= core.cpu_io_out;
               end else begin
                  run_check <= 1'b1;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign busy = (state != ST_IDLE);
   assign done = (state == ST_DONE);

endmodule

// File: tb/tb_pdp_sequencer.sv
// Scoreboard bench for pdp_sequencer: a behavioural accumulator core answers the command bus,
// and a reference run of each program predicts the command stream, step count, halt and done cycle.
`timescale 1ns/1ps
module tb_pdp_sequencer;
   import pdp_pkg::*;

   typedef struct {
      int done_cycle;
      int steps;
      bit halted;
   } result_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        abort;
   logic [15:0] prog_code;
   logic [31:0] prog_data;
   logic [2:0]  start_pc;
   logic [7:0]  run_steps;
   logic        busy;
   logic        done;
   logic        halted;
   logic [7:0]  steps_taken;

   int checks   = 0;
   int failures = 0;
   int cycle    = 0;
   int ops_seen = 0;

   logic [5:0] exp_ops[$];
   result_t    exp_res[$];
   logic [7:0] prev_io = 8'h00;

   pdp_sequencer_if #(.CORE_IO_W(8)) bus_if ();

   pdp_sequencer #(.STEP_W(8), .CORE_IO_W(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .abort       (abort),
      .prog_code   (prog_code),
      .prog_data   (prog_data),
      .start_pc    (start_pc),
      .run_steps   (run_steps),
      .core        (bus_if),
      .busy        (busy),
      .done        (done),
      .halted      (halted),
      .steps_taken (steps_taken)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   // One instruction of the core: operands come from the data slot at pc, Bz branches to data[pc] when acc is zero.
   function automatic logic [38:0] exec_step(input logic [15:0] code, input logic [31:0] data,
                                             input logic [2:0] pc, input logic [3:0] acc);
      logic [1:0] ins;
      logic [3:0] opnd;
      int idx;
      idx  = int'(pc);
      ins  = code[idx*2 +: 2];
      opnd = data[idx*4 +: 4];
      case (ins)
         INSTR_LOAD: begin
            acc = opnd;
            pc  = pc + 3'd1;
         end
         INSTR_STORE: begin
            data[idx*4 +: 4] = acc;
            pc = pc + 3'd1;
         end
         INSTR_ADD: begin
            acc = acc + opnd;
            pc  = pc + 3'd1;
         end
         default: pc = (acc == 4'd0) ? opnd[2:0] : pc + 3'd1;
      endcase
      return {data, pc, acc};
   endfunction

   logic [15:0] core_code = '0;
   logic [31:0] core_data = '0;
   logic [2:0]  core_pc   = '0;
   logic [3:0]  core_acc  = '0;
   logic        cpu_clk;

   assign cpu_clk           = bus_if.cpu_io_in[0];
   assign bus_if.cpu_io_out = {1'b0, core_pc, core_acc};

   always @(posedge cpu_clk) begin
      case (bus_if.cpu_io_in[2:1])
         2'd0: begin
            core_pc  = bus_if.cpu_io_in[6:4];
            core_acc = 4'd0;
         end
         2'd1: begin
            core_code[int'(core_pc)*2 +: 2] = bus_if.cpu_io_in[5:4];
            core_pc = core_pc + 3'd1;
         end
         2'd2: begin
            core_data[int'(core_pc)*4 +: 4] = bus_if.cpu_io_in[7:4];
            core_pc = core_pc + 3'd1;
         end
         default: {core_data, core_pc, core_acc} = exec_step(core_code, core_data, core_pc, core_acc);
      endcase
   end

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
      end
   endtask

   // Monitor: every cpu_clk rise pops one expected op, every done pulse pops one expected result.
   always @(negedge clk) begin
      logic [5:0] e;
      result_t r;
      if (rst_n) begin
         if (bus_if.cpu_io_in[0] && !prev_io[0]) begin
            ops_seen++;
            checkOutput("op_expected", exp_ops.size() > 0, 1);
            if (exp_ops.size() > 0) begin
               e = exp_ops.pop_front();
               checkOutput("op_pulse", bus_if.cpu_io_in[7:1], {e[5:2], 1'b0, e[1:0]});
               checkOutput("op_setup", prev_io[7:1], {e[5:2], 1'b0, e[1:0]});
            end
         end
         if (done) begin
            checkOutput("done_expected", exp_res.size() > 0, 1);
            if (exp_res.size() > 0) begin
               r = exp_res.pop_front();
               checkOutput("done_cycle", cycle, r.done_cycle);
               checkOutput("steps_taken", steps_taken, r.steps);
               checkOutput("halted", halted, r.halted);
            end
         end
      end
      prev_io = bus_if.cpu_io_in;
   end

   task automatic applyStimulus(input logic [15:0] code, input logic [31:0] data,
                                input logic [2:0] pc0, input logic [7:0] limit, output int t);
      logic [31:0] d;
      logic [2:0]  pc;
      logic [3:0]  acc;
      logic [38:0] nxt;
      int          taken;
      bit          hlt;
      result_t     r;
      @(negedge clk);
      prog_code = code;
      prog_data = data;
      start_pc  = pc0;
      run_steps = limit;
      start     = 1'b1;
      t         = cycle;
      exp_ops.push_back({4'd0, CMD_RESET});
      for (int i = 0; i < 8; i++) exp_ops.push_back({2'b00, code[i*2 +: 2], CMD_LOAD_CODE});
      exp_ops.push_back({4'd0, CMD_RESET});
      for (int i = 0; i < 8; i++) exp_ops.push_back({data[i*4 +: 4], CMD_LOAD_DATA});
      exp_ops.push_back({1'b0, pc0, CMD_RESET});
      d     = data;
      pc    = pc0;
      acc   = 4'd0;
      taken = 0;
      hlt   = 1'b0;
      while (taken < int'(limit) && !hlt) begin
         exp_ops.push_back({4'd0, CMD_RUN});
         nxt = exec_step(code, d, pc, acc);
         taken++;
         if (nxt[6:0] == {pc, acc}) hlt = 1'b1;
         d   = nxt[38:7];
         pc  = nxt[6:4];
         acc = nxt[3:0];
      end
      r.done_cycle = t + 39 + 3*taken;
      r.steps      = taken;
      r.halted     = hlt;
      exp_res.push_back(r);
      @(negedge clk);
      start = 1'b0;
      checkOutput("busy_after_start", busy, 1);
      checkOutput("halted_cleared", halted, 0);
      checkOutput("steps_cleared", steps_taken, 0);
   endtask

   task automatic waitIdle(input string name);
      int n;
      n = 0;
      while ((busy || exp_res.size() != 0) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      checkOutput({name, "_timeout"}, n >= 3000, 0);
      checkOutput({name, "_ops_left"}, exp_ops.size(), 0);
   endtask

   task automatic checkResetValues(input string name);
      checkOutput({name, "_io"}, bus_if.cpu_io_in, 0);
      checkOutput({name, "_busy"}, busy, 0);
      checkOutput({name, "_done"}, done, 0);
      checkOutput({name, "_halted"}, halted, 0);
      checkOutput({name, "_steps"}, steps_taken, 0);
   endtask

   localparam logic [15:0] S1_CODE = {2'd3, 2'd2, 2'd1, 2'd0, 2'd1, 2'd2, 2'd1, 2'd0};
   localparam logic [31:0] S1_DATA = {4'd7, 4'd8, 4'd2, 4'd9, 4'd0, 4'd1, 4'd4, 4'd1};

   initial begin
      int t;
      int ops_before;
      logic [31:0] rnd_data;
      rst_n     = 1'b0;
      start     = 1'b0;
      abort     = 1'b0;
      prog_code = '0;
      prog_data = '0;
      start_pc  = '0;
      run_steps = '0;
      repeat (3) @(negedge clk);
      checkResetValues("reset");
      rst_n = 1'b1;
      @(negedge clk);

      applyStimulus(S1_CODE, S1_DATA, 3'd0, 8'd10, t);
      waitIdle("s1");
      checkOutput("s1_steps", steps_taken, 10);
      checkOutput("s1_halted", halted, 0);

      applyStimulus(16'hFFFF, 32'h0, 3'd0, 8'd50, t);
      waitIdle("s2");
      checkOutput("s2_steps", steps_taken, 1);
      checkOutput("s2_halted", halted, 1);
      repeat (5) @(negedge clk);
      checkOutput("s2_halted_sticky", halted, 1);

      applyStimulus(16'h1B6C, 32'h89ABCDEF, 3'd5, 8'd0, t);
      waitIdle("s3");
      checkOutput("s3_steps", steps_taken, 0);

      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      checkOutput("abort_beats_start", busy, 0);

      rnd_data   = $urandom;
      ops_before = ops_seen;
      applyStimulus(16'($urandom), rnd_data, 3'd2, 8'd5, t);
      while (cycle < t + 27) @(negedge clk);
      checkOutput("abort_slot3_setup", bus_if.cpu_io_in, {rnd_data[15:12], 1'b0, 2'd2, 1'b0});
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_io", bus_if.cpu_io_in, 0);
      checkOutput("abort_ops_seen", ops_seen - ops_before, 13);
      checkOutput("abort_steps_hold", steps_taken, 0);
      exp_ops.delete();
      exp_res.delete();
      repeat (4) @(negedge clk);
      applyStimulus(S1_CODE, S1_DATA, 3'd0, 8'd10, t);
      waitIdle("after_abort");

      applyStimulus(S1_CODE, S1_DATA, 3'd0, 8'd10, t);
      while (cycle < t + 50) @(negedge clk);
      checkOutput("pre_reset_steps", steps_taken, 3);
      rst_n = 1'b0;
      #1;
      checkResetValues("mid_reset");
      exp_ops.delete();
      exp_res.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      applyStimulus(S1_CODE, S1_DATA, 3'd0, 8'd10, t);
      waitIdle("after_reset");
      checkOutput("after_reset_steps", steps_taken, 10);
      checkOutput("after_reset_halted", halted, 0);

      // Random programs, with a start pulse mid-run and scrambled inputs that must be ignored.
      for (int k = 0; k < 6; k++) begin
         applyStimulus(16'($urandom), $urandom, 3'($urandom_range(0, 7)),
                       8'($urandom_range(0, 24)), t);
         repeat (4) @(negedge clk);
         prog_code = ~prog_code;
         prog_data = ~prog_data;
         start_pc  = start_pc + 3'd3;
         run_steps = run_steps + 8'd7;
         start     = 1'b1;
         @(negedge clk);
         start = 1'b0;
         waitIdle("random");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached before summary");
      $fatal(1);
   end

endmodule
